// File: rtl/mem_access_master_if.sv
// mem_access_master_if: request/response handshake plus single-word memory bus of mem_access_master.
// Rev 1.0
`default_nettype none

interface mem_access_master_if #(
  parameter int BEATS = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic                  req_vector;
  logic [31:0]           req_addr;
  logic [32*BEATS-1:0]   req_wdata;
  logic                  resp_valid;
  logic [32*BEATS-1:0]   resp_rdata;
  logic                  resp_error;
  logic [31:0]           data_address;
  logic                  write_enable;
  logic [31:0]           data_input;
  logic [31:0]           data_output;

  modport master (
    input  req_valid, req_write, req_vector, req_addr, req_wdata, data_output,
    output req_ready, resp_valid, resp_rdata, resp_error, data_address, write_enable, data_input
  );

  modport slave (
    output req_valid, req_write, req_vector, req_addr, req_wdata, data_output,
    input  req_ready, resp_valid, resp_rdata, resp_error, data_address, write_enable, data_input
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_master.sv
// mem_access_master: splits scalar/vector load-store requests into single-word memory beats. Rev 1.0
// Define ALIGN_CHECK_EN to reject misaligned requests with resp_error instead of forcing alignment.
`default_nettype none

module mem_access_master #(
  parameter int BEATS        = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_master_if.master bus,
  output logic                busy
);
  localparam int            DW      = 32 * BEATS;
  localparam int            CW      = $clog2(BEATS + 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_BEATS = CW'(BEATS);

  typedef enum logic [2:0] {S_RST, S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] n_beats;
  logic [31:0]   base_q;
  logic          store_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rbuf;
  logic [DW-1:0] rbuf_merged;
  logic          sr_valid [READ_LATENCY+1];
  logic [CW-1:0] sr_idx   [READ_LATENCY+1];
  logic          misaligned;
  logic [31:0]   base_addr;
  logic          cap;
  logic          cap_last;

`ifdef ALIGN_CHECK_EN
  assign misaligned = (bus.req_addr[1:0] != 2'b00);
  assign base_addr  = bus.req_addr;
`else
  assign misaligned = 1'b0;
  assign base_addr  = {bus.req_addr[31:2], 2'b00};
`endif

  // The tag at the tail of the shift register marks the beat whose data is on data_output now.
  assign cap      = sr_valid[READ_LATENCY];
  assign cap_last = cap && (sr_idx[READ_LATENCY] == n_beats - C_ONE);

  always_comb begin
    rbuf_merged = rbuf;
    if (cap) begin
      rbuf_merged[32*int'(sr_idx[READ_LATENCY]) +: 32] = bus.data_output;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_RST;
      bus.req_ready    <= 1'b0;
      bus.resp_valid   <= 1'b0;
      bus.resp_error   <= 1'b0;
      bus.resp_rdata   <= '0;
      bus.data_address <= '0;
      bus.write_enable <= 1'b0;
      bus.data_input   <= '0;
      busy             <= 1'b0;
      beat_cnt         <= '0;
      n_beats          <= '0;
      base_q           <= '0;
      store_q          <= 1'b0;
      wdata_q          <= '0;
      rbuf             <= '0;
      for (int j = 0; j <= READ_LATENCY; j++) begin
        sr_valid[j] <= 1'b0;
        sr_idx[j]   <= '0;
      end
    end else begin
      for (int j = READ_LATENCY; j > 0; j--) begin
        sr_valid[j] <= sr_valid[j-1];
        sr_idx[j]   <= sr_idx[j-1];
      end
      sr_valid[0] <= 1'b0;
      if (cap) begin
        rbuf <= rbuf_merged;
      end

      case (state)
        S_RST: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end

        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            if (misaligned) begin
              state          <= S_DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_error <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              // Beat 0 goes out on the acceptance edge itself.
              state            <= S_ISSUE;
              base_q           <= base_addr;
              store_q          <= bus.req_write;
              wdata_q          <= bus.req_wdata;
              n_beats          <= bus.req_vector ? C_BEATS : C_ONE;
              beat_cnt         <= C_ONE;
              rbuf             <= '0;
              bus.data_address <= base_addr;
              bus.write_enable <= bus.req_write;
              bus.data_input   <= bus.req_write ? bus.req_wdata[31:0] : 32'd0;
              sr_valid[0]      <= !bus.req_write;
              sr_idx[0]        <= '0;
            end
          end
        end

        S_ISSUE: begin
          if (beat_cnt < n_beats) begin
            bus.data_address <= base_q + (32'(beat_cnt) << 2);
            bus.write_enable <= store_q;
            bus.data_input   <= store_q ? wdata_q[32*int'(beat_cnt) +: 32] : 32'd0;
            sr_valid[0]      <= !store_q;
            sr_idx[0]        <= beat_cnt;
            beat_cnt         <= beat_cnt + C_ONE;
          end else begin
            bus.data_address <= '0;
            bus.write_enable <= 1'b0;
            bus.data_input   <= '0;
            if (store_q) begin
              state          <= S_DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_error <= 1'b0;
            end else begin
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (cap_last) begin
            state          <= S_DONE;
            bus.resp_valid <= 1'b1;
            bus.resp_error <= 1'b0;
            bus.resp_rdata <= rbuf_merged;
          end
        end

        S_DONE: begin
          state          <= S_IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_error <= 1'b0;
          bus.req_ready  <= 1'b1;
          busy           <= 1'b0;
        end

        default: state <= S_RST;
      endcase
    end
  end
endmodule

`default_nettype wire
